fmc_i2c_target: RTL and testbench

//  I2C target (responder) for the FMC424 control bus: the bus-side counterpart of fmc_i2c_controller.

---
 rtl/fmc_i2c_pkg.sv | 22 ++
 rtl/fmc_i2c_target_line_filter.sv | 46 ++++
 rtl/fmc_i2c_target.sv | 170 +++++++++++++++++
 tb/tb_fmc_i2c_target.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmc_i2c_pkg.sv
// Shared types and bus addresses for the FMC424 I2C control-bus blocks.
`timescale 1ns/1ps
package fmc_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_tgt_state_t;

    localparam logic [6:0] CPLD_ADDR    = 7'h3E;
    localparam logic [6:0] SI5338B_ADDR = 7'h70;
    localparam logic [6:0] QSFP_ADDR    = 7'h50;

endpackage

// File: rtl/fmc_i2c_target_line_filter.sv
// Pin synchronizer plus glitch filter for one I2C line, with 1-clk rise/fall pulses.
`timescale 1ns/1ps
module i2c_line_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   sample;

    assign sample = sync[SYNC_STAGES-1];

    // A new level is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '1;
            level <= 1'b1;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sample;
                cnt   <= '0;
                rise  <= sample;
                fall  <= ~sample;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fmc_i2c_target.sv
// I2C target emulating the FMC424 CPLD: single address, 8-bit auto-incrementing register pointer.
`timescale 1ns/1ps
module fmc_i2c_target
    import fmc_i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = CPLD_ADDR,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_pin_val,
    input  logic       sda_pin_val,
    output logic       scl_t,
    output logic       scl_write,
    output logic       sda_t,
    output logic       sda_write,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wdata,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk(clk), .reset(reset), .pin(scl_pin_val),
        .level(scl_f), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk(clk), .reset(reset), .pin(sda_pin_val),
        .level(sda_f), .rise(sda_rise), .fall(sda_fall)
    );

    assign scl_t     = 1'b1;
    assign scl_write = 1'b0;
    assign sda_write = 1'b0;

    i2c_tgt_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] rx, tx, rx_next;
    logic       rw, ack_on, rd_acked;
    logic       start, stop;

    assign start   = sda_fall & scl_f;
    assign stop    = sda_rise & scl_f;
    assign rx_next = {rx[6:0], sda_f};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            ack_on    <= 1'b0;
            rd_acked  <= 1'b0;
            sda_t     <= 1'b1;
            busy      <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            if (stop) begin
                state  <= IDLE;
                sda_t  <= 1'b1;
                busy   <= 1'b0;
                ack_on <= 1'b0;
            end else if (start) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_t   <= 1'b1;
                ack_on  <= 1'b0;
            end else begin
                // Read data arrives the cycle after the strobe; drive MSB only once in RD_DATA.
                if (reg_rd_en) begin
                    tx <= reg_rdata;
                    if (state == RD_DATA) sda_t <= reg_rdata[7];
                end
                case (state)
                    ADDR, PTR, WR_DATA: begin
                        if (scl_rise) begin
                            rx      <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_on <= 1'b0;
                                if (state == ADDR) begin
                                    if (rx[6:0] == TARGET_ADDR) begin
                                        rw    <= sda_f;
                                        state <= ADDR_ACK;
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end else if (state == PTR) begin
                                    reg_addr <= rx_next;
                                    state    <= PTR_ACK;
                                end else begin
                                    reg_wdata <= rx_next;
                                    reg_wr_en <= 1'b1;
                                    state     <= WR_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WR_ACK: begin
                        // First fall starts the ACK bit, second fall ends it.
                        if (scl_fall) begin
                            if (!ack_on) begin
                                ack_on <= 1'b1;
                                sda_t  <= 1'b0;
                                if (state == ADDR_ACK) busy <= 1'b1;
                            end else begin
                                ack_on  <= 1'b0;
                                bit_cnt <= '0;
                                if (state == ADDR_ACK && rw) begin
                                    reg_rd_en <= 1'b1;
                                    state     <= RD_DATA;
                                end else begin
                                    sda_t <= 1'b1;
                                    if (state == ADDR_ACK) begin
                                        state <= PTR;
                                    end else begin
                                        state <= WR_DATA;
                                        if (state == WR_ACK) reg_addr <= reg_addr + 8'd1;
                                    end
                                end
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_t    <= 1'b1;
                                rd_acked <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                tx    <= {tx[6:0], 1'b0};
                                sda_t <= tx[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                rd_acked  <= 1'b1;
                                reg_addr  <= reg_addr + 8'd1;
                                reg_rd_en <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                        if (scl_fall && rd_acked) begin
                            sda_t   <= tx[7];
                            bit_cnt <= '0;
                            state   <= RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fmc_i2c_target.sv
// Directed bench: bus-level I2C controller, register-file model and strobe scoreboard.
`timescale 1ns/1ps
module tb_fmc_i2c_target;
    import fmc_i2c_pkg::*;

    localparam int Q = 100;  // quarter SCL period (10 clk)

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_pin_val, sda_pin_val;
    logic       scl_t, scl_write, sda_t, sda_write;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr_en, reg_rd_en, busy;

    assign scl_pin_val = m_scl & (scl_t | scl_write);
    assign sda_pin_val = m_sda & (sda_t | sda_write);

    always #5 clk = ~clk;

    fmc_i2c_target #(.TARGET_ADDR(CPLD_ADDR), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .clk(clk), .reset(reset),
        .scl_pin_val(scl_pin_val), .sda_pin_val(sda_pin_val),
        .scl_t(scl_t), .scl_write(scl_write), .sda_t(sda_t), .sda_write(sda_write),
        .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
        .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy)
    );

    // Register file model: combinational read, so data is ready at the edge after reg_rd_en.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (reset) begin
            mem[8'hFF] <= 8'hC3;
            mem[8'h00] <= 8'h3C;
        end else if (reg_wr_en) begin
            mem[reg_addr] <= reg_wdata;
        end
    end
    assign reg_rdata = mem[reg_addr];

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    logic [15:0] wexp;
    logic [7:0]  rexp;
    bit watch = 1'b0;
    int viol = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe scoreboard: every strobe must match the next expected register access.
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wr_en) begin
                if (wq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_wr: got addr %0h data %0h expected no write", reg_addr, reg_wdata);
                end else begin
                    wexp = wq.pop_front();
                    chk("wr_strobe", {reg_addr, reg_wdata}, wexp);
                end
            end
            if (reg_rd_en) begin
                if (rq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_rd: got addr %0h expected no read", reg_addr);
                end else begin
                    rexp = rq.pop_front();
                    chk("rd_strobe", 16'(reg_addr), 16'(rexp));
                end
            end
            if (watch && sda_t !== 1'b1) viol++;
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
    endtask

    // Optional glitch: a 2-clk low pulse on SCL in the middle of the high phase.
    task automatic bit_out(input logic b, input bit glitch);
        m_sda = b; #Q; m_scl = 1'b1;
        if (glitch) begin
            #40; m_scl = 1'b0; #20; m_scl = 1'b1; #140;
        end else begin
            #(2*Q);
        end
        m_scl = 1'b0; #Q;
    endtask

    task automatic sample_bit(output logic v);
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; v = sda_pin_val; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i], glitch && i == 3);
        sample_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            sample_bit(v);
            d[i] = v;
        end
        bit_out(nack, 1'b0);
    endtask

    logic       a;
    logic [7:0] d0, d1;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #50;
        chk("rst_sda_t", 16'(sda_t), 16'd1);
        chk("rst_sda_write", 16'(sda_write), 16'd0);
        chk("rst_scl_t", 16'(scl_t), 16'd1);
        chk("rst_scl_write", 16'(scl_write), 16'd0);
        chk("rst_reg_addr", 16'(reg_addr), 16'd0);
        chk("rst_reg_wdata", 16'(reg_wdata), 16'd0);
        chk("rst_strobes", 16'({reg_wr_en, reg_rd_en}), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        #50; reset = 1'b0; #200;

        // Write two bytes from pointer 0x10; second byte carries an SCL glitch.
        wq.push_back({8'h10, 8'hA5});
        wq.push_back({8'h11, 8'h5A});
        i2c_start();
        chk("busy_before_ack", 16'(busy), 16'd0);
        write_byte(8'h7C, 1'b0, a); chk("wr_addr_ack", 16'(a), 16'd0);
        chk("busy_after_addr", 16'(busy), 16'd1);
        write_byte(8'h10, 1'b0, a); chk("wr_ptr_ack", 16'(a), 16'd0);
        write_byte(8'hA5, 1'b0, a); chk("wr_d0_ack", 16'(a), 16'd0);
        write_byte(8'h5A, 1'b1, a); chk("wr_d1_glitch_ack", 16'(a), 16'd0);
        i2c_stop();
        chk("busy_after_stop", 16'(busy), 16'd0);
        chk("mem_10", 16'(mem[8'h10]), 16'h00A5);
        chk("mem_11", 16'(mem[8'h11]), 16'h005A);
        chk("wq_drained_write", 16'(wq.size()), 16'd0);

        // Pointer set to 0xFF, repeated START, read two bytes across the wrap.
        rq.push_back(8'hFF);
        rq.push_back(8'h00);
        i2c_start();
        write_byte(8'h7C, 1'b0, a); chk("rd_waddr_ack", 16'(a), 16'd0);
        write_byte(8'hFF, 1'b0, a); chk("rd_ptr_ack", 16'(a), 16'd0);
        i2c_start();
        write_byte(8'h7D, 1'b0, a); chk("rd_raddr_ack", 16'(a), 16'd0);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop();
        chk("rd_byte0_model", 16'(d0), 16'(mem[8'hFF]));
        chk("rd_byte0", 16'(d0), 16'h00C3);
        chk("rd_byte1", 16'(d1), 16'h003C);
        chk("rd_ptr_after", 16'(reg_addr), 16'h0000);
        chk("rq_drained_read", 16'(rq.size()), 16'd0);
        chk("busy_after_read", 16'(busy), 16'd0);

        // Address mismatch: SI5338B write must never be acknowledged.
        watch = 1'b1; viol = 0;
        i2c_start();
        write_byte({SI5338B_ADDR, 1'b0}, 1'b0, a); chk("mis_addr_nack", 16'(a), 16'd1);
        chk("mis_busy", 16'(busy), 16'd0);
        write_byte(8'h55, 1'b0, a); chk("mis_data_nack", 16'(a), 16'd1);
        i2c_stop();
        watch = 1'b0;
        chk("mis_sda_released", 16'(viol), 16'd0);

        // Address + pointer only: no write strobe.
        i2c_start();
        write_byte(8'h7C, 1'b0, a); chk("ptronly_addr_ack", 16'(a), 16'd0);
        write_byte(8'h30, 1'b0, a); chk("ptronly_ptr_ack", 16'(a), 16'd0);
        i2c_stop();
        chk("ptronly_ptr", 16'(reg_addr), 16'h0030);

        // Abort: STOP after 4 bits of a data byte.
        i2c_start();
        write_byte(8'h7C, 1'b0, a); chk("abort_addr_ack", 16'(a), 16'd0);
        write_byte(8'h20, 1'b0, a); chk("abort_ptr_ack", 16'(a), 16'd0);
        for (int i = 0; i < 4; i++) bit_out(1'b1, 1'b0);
        i2c_stop();
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_no_write", 16'(mem[8'h20] === 8'hFF), 16'd0);

        // Reset while the target drives a 0 data bit.
        rq.push_back(8'h00);
        i2c_start();
        write_byte(8'h7C, 1'b0, a); chk("rst_rd_waddr_ack", 16'(a), 16'd0);
        write_byte(8'h00, 1'b0, a); chk("rst_rd_ptr_ack", 16'(a), 16'd0);
        i2c_start();
        write_byte(8'h7D, 1'b0, a); chk("rst_rd_raddr_ack", 16'(a), 16'd0);
        chk("rst_rd_driving_low", 16'(sda_t), 16'd0);
        #3; reset = 1'b1; #1;
        chk("rst_rd_sda_release", 16'(sda_t), 16'd1);
        chk("rst_rd_busy", 16'(busy), 16'd0);
        chk("rst_rd_addr", 16'(reg_addr), 16'd0);
        #6; m_scl = 1'b1; m_sda = 1'b1; #100; reset = 1'b0; #200;
        i2c_start();
        write_byte(8'h7C, 1'b0, a); chk("post_rst_ack", 16'(a), 16'd0);
        chk("post_rst_busy", 16'(busy), 16'd1);
        i2c_stop();
        chk("post_rst_busy_stop", 16'(busy), 16'd0);

        chk("wq_final", 16'(wq.size()), 16'd0);
        chk("rq_final", 16'(rq.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
